// File: rtl/period_capture_if.sv
// Signal bundle for period_capture: control/event inputs and measurement results.
// The master side drives en/sig_in/ps; the slave (the capture block) drives the results.
interface period_capture_if #(
  parameter int COUNT_BITS  = 8,
  parameter int SCALER_BITS = 2
);
  logic                   en;
  logic                   sig_in;
  logic [SCALER_BITS-1:0] ps;
  logic [COUNT_BITS-1:0]  capture;
  logic                   valid;
  logic                   ovf;
  logic                   busy;

  modport master (
    output en, sig_in, ps,
    input  capture, valid, ovf, busy
  );

  modport slave (
    input  en, sig_in, ps,
    output capture, valid, ovf, busy
  );
endinterface

// File: rtl/period_capture.sv
// Measures the interval between rising edges of an asynchronous input in units of
// 2**ps clocks, saturating at the counter width and flagging the saturation.
module period_capture #(
  parameter int COUNT_BITS  = 8,
  parameter int SCALER_BITS = 2
) (
  input logic             clk,
  input logic             rst,
  period_capture_if.slave bus
);

  // Scaler must reach 2**(2**SCALER_BITS-1)-1, so one bit per possible ps step.
  localparam int SC_BITS = 2 ** SCALER_BITS;
  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                 state;
  logic                   s1, s2, s3;
  logic [COUNT_BITS-1:0]  counter;
  logic [COUNT_BITS-1:0]  capture_q;
  logic [SC_BITS-1:0]     scaler;
  logic [SC_BITS-1:0]     scaler_max;
  logic [SCALER_BITS-1:0] ps_q;
  logic                   sat;
  logic                   valid_q;
  logic                   ovf_q;
  logic                   busy_q;
  logic                   edge_det;
  logic                   unit_done;
  logic                   cnt_max;

  assign edge_det   = s2 & ~s3;
  assign scaler_max = (SC_BITS'(1) << ps_q) - SC_BITS'(1);
  assign unit_done  = (scaler == scaler_max);
  assign cnt_max    = (counter == CNT_MAX);

  // Synchronizer and edge history run independently of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      scaler    <= '0;
      sat       <= 1'b0;
      ps_q      <= '0;
      capture_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.en) begin
        state   <= IDLE;
        busy_q  <= 1'b0;
        counter <= '0;
        scaler  <= '0;
        sat     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (edge_det) begin
              state   <= MEASURE;
              busy_q  <= 1'b1;
              counter <= '0;
              scaler  <= '0;
              sat     <= 1'b0;
              ps_q    <= bus.ps;
            end
          end
          MEASURE: begin
            if (edge_det) begin
              // The closing clock of the interval still counts if it completes a unit.
              capture_q <= (unit_done && !cnt_max) ? counter + COUNT_BITS'(1) : counter;
              ovf_q     <= sat | (unit_done & cnt_max);
              valid_q   <= 1'b1;
              counter   <= '0;
              scaler    <= '0;
              sat       <= 1'b0;
              ps_q      <= bus.ps;
            end else if (unit_done) begin
              scaler <= '0;
              if (cnt_max) begin
                sat <= 1'b1;
              end else begin
                counter <= counter + COUNT_BITS'(1);
              end
            end else begin
              scaler <= scaler + SC_BITS'(1);
            end
          end
        endcase
      end
    end
  end

  assign bus.capture = capture_q;
  assign bus.valid   = valid_q;
  assign bus.ovf     = ovf_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_period_capture.sv
// Directed bench for period_capture: edge-timing table plus en-drop and reset sequences.
module tb_period_capture;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  period_capture_if #(.COUNT_BITS(8), .SCALER_BITS(2)) bus ();

  period_capture #(.COUNT_BITS(8), .SCALER_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int gap;       // clocks until the next rising edge
    int ps_next;   // ps applied mid-gap, latched by the next edge
    bit exp_valid;
    int exp_cap;
    bit exp_ovf;
    bit exp_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a rising edge now (at a negedge), check its effect three negedges later,
  // and return exactly gap clocks later so edges are spaced by gap.
  task automatic edge_run(input int gap, input int ps_next, input bit ev, input int ecap,
                          input bit eovf, input bit ebusy, input string tag);
    bus.sig_in = 1'b1;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk);
      if (i == 3) begin
        $display("edge %s: valid=%0d capture=%0d ovf=%0d busy=%0d", tag,
                 bus.valid, bus.capture, bus.ovf, bus.busy);
        chk({tag, " valid"}, int'(bus.valid), int'(ev));
        chk({tag, " capture"}, int'(bus.capture), ecap);
        chk({tag, " ovf"}, int'(bus.ovf), int'(eovf));
        chk({tag, " busy"}, int'(bus.busy), int'(ebusy));
      end
      if (i == 4) chk({tag, " valid_pulse"}, int'(bus.valid), 0);
      if (i == 5) bus.ps = 2'(ps_next);
      if (i == gap / 2) bus.sig_in = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{10,  0, 1'b0,   0, 1'b0, 1'b1};
    vecs[1]  = '{10,  2, 1'b1,  10, 1'b0, 1'b1};
    vecs[2]  = '{40,  2, 1'b1,  10, 1'b0, 1'b1};
    vecs[3]  = '{43,  0, 1'b1,  10, 1'b0, 1'b1};
    vecs[4]  = '{300, 0, 1'b1,  10, 1'b0, 1'b1};
    vecs[5]  = '{20,  0, 1'b1, 255, 1'b1, 1'b1};
    vecs[6]  = '{10,  3, 1'b1,  20, 1'b0, 1'b1};
    vecs[7]  = '{10,  3, 1'b1,  10, 1'b0, 1'b1};
    vecs[8]  = '{10,  0, 1'b1,   1, 1'b0, 1'b1};
    vecs[9]  = '{10,  0, 1'b1,   1, 1'b0, 1'b1};
    vecs[10] = '{10,  0, 1'b1,  10, 1'b0, 1'b1};

    rst        = 1'b1;
    bus.en     = 1'b1;
    bus.sig_in = 1'b0;
    bus.ps     = 2'd0;
    repeat (3) @(negedge clk);
    $display("reset: capture=%0d valid=%0d ovf=%0d busy=%0d",
             bus.capture, bus.valid, bus.ovf, bus.busy);
    chk("reset capture", int'(bus.capture), 0);
    chk("reset valid", int'(bus.valid), 0);
    chk("reset ovf", int'(bus.ovf), 0);
    chk("reset busy", int'(bus.busy), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle busy", int'(bus.busy), 0);

    for (int v = 0; v < 11; v++) begin
      edge_run(vecs[v].gap, vecs[v].ps_next, vecs[v].exp_valid, vecs[v].exp_cap,
               vecs[v].exp_ovf, vecs[v].exp_busy, $sformatf("vec%0d", v));
    end

    // en dropped mid-interval: FSM idles, results hold, next edge only re-arms.
    repeat (3) @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("en_low busy", int'(bus.busy), 0);
      chk("en_low valid", int'(bus.valid), 0);
    end
    $display("en_low: capture=%0d busy=%0d", bus.capture, bus.busy);
    chk("en_low capture", int'(bus.capture), 10);
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    edge_run(10, 0, 1'b0, 10, 1'b0, 1'b1, "rearm");
    edge_run(10, 0, 1'b1, 10, 1'b0, 1'b1, "after_rearm");

    // Reset mid-interval with sig_in high: results clear, release counts as an edge.
    repeat (3) @(negedge clk);
    rst        = 1'b1;
    bus.sig_in = 1'b1;
    #1;
    $display("rst_mid: capture=%0d ovf=%0d busy=%0d valid=%0d",
             bus.capture, bus.ovf, bus.busy, bus.valid);
    chk("rst_mid capture", int'(bus.capture), 0);
    chk("rst_mid ovf", int'(bus.ovf), 0);
    chk("rst_mid busy", int'(bus.busy), 0);
    chk("rst_mid valid", int'(bus.valid), 0);
    repeat (3) @(negedge clk);
    chk("rst_hold busy", int'(bus.busy), 0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        $display("rst_release: valid=%0d capture=%0d busy=%0d",
                 bus.valid, bus.capture, bus.busy);
        chk("rst_release busy", int'(bus.busy), 1);
        chk("rst_release valid", int'(bus.valid), 0);
        chk("rst_release capture", int'(bus.capture), 0);
      end
      if (i == 5) bus.sig_in = 1'b0;
    end
    edge_run(10, 0, 1'b1, 10, 1'b0, 1'b1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/period_capture.md
PERIOD_CAPTURE -- requirements
Module: period_capture

Interface
REQ-001 The module SHALL have parameter COUNT_BITS, default 8, giving the width of the period counter and capture register.
REQ-002 The module SHALL have parameter SCALER_BITS, default 2, giving the width of the pre-scale select.
REQ-003 The module SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have port en, input, 1 bit: capture enable.
REQ-006 The module SHALL have port sig_in, input, 1 bit: asynchronous event input; rising edges delimit periods.
REQ-007 The module SHALL have port ps, input, SCALER_BITS: pre-scale select; one count unit = 2**ps clocks.
REQ-008 The module SHALL have port capture, output, COUNT_BITS: last measured period in count units.
REQ-009 The module SHALL have port valid, output, 1 bit: one-cycle pulse when capture and ovf update.
REQ-010 The module SHALL have port ovf, output, 1 bit: the last captured period saturated.
REQ-011 The module SHALL have port busy, output, 1 bit: high while in state MEASURE.

Function
REQ-012 sig_in SHALL pass through a two-flop synchronizer (s1, s2) plus history flop s3; edge = s2 & ~s3; the synchronizer runs regardless of en.
REQ-013 A sig_in rising edge sampled at clock edge k SHALL be acted on (arm or capture) at clock edge k+2.
REQ-014 sig_in high and low phases SHALL each be at least 2 clocks; shorter pulses may be missed and are not a defect.
REQ-015 The FSM SHALL have two states: IDLE (waiting for first edge) and MEASURE (counting between edges).
REQ-016 IDLE with en=1 and edge: go to MEASURE, counter=0, scaler=0, latch ps into ps_q; no valid.
REQ-017 MEASURE with en=1 and no edge: scaler increments; when scaler == 2**ps_q-1, scaler wraps to 0 and counter increments.
REQ-018 Counter increment at value 2**COUNT_BITS-1 SHALL saturate (hold) and set internal flag sat.
REQ-019 MEASURE with en=1 and edge: capture <= counter+1 if scaler == 2**ps_q-1 and counter not saturated, else counter; ovf <= sat (or the saturating increment); valid=1 for that one cycle; counter, scaler, sat cleared; ps_q reloaded from ps; state stays MEASURE.
REQ-020 Result: an edge-to-edge period of P clocks SHALL yield capture = min(floor(P / 2**ps_q), 2**COUNT_BITS-1).
REQ-021 ps changes mid-interval SHALL take effect only at the next arm or capture edge (ps_q).
REQ-022 en=0 SHALL force IDLE, clear counter, scaler and sat, and hold valid=0; capture and ovf SHALL hold their values.
REQ-023 valid SHALL never be high for two consecutive cycles; between captures it is 0.
REQ-024 busy SHALL equal (state == MEASURE), registered.

Reset
REQ-025 rst=1 SHALL immediately force: state IDLE, s1=s2=s3=0, counter=0, scaler=0, sat=0, ps_q=0, capture=0, valid=0, ovf=0, busy=0.
REQ-026 If sig_in is high when rst is released, the resulting synchronized 0->1 transition SHALL count as an edge (arms FSM when en=1).
REQ-027 rst asserted mid-measurement SHALL discard the in-progress interval; no valid is produced for it.

Verification
REQ-028 ps=0, en=1, sig_in edges every 10 clocks -> first edge: busy=1, no valid; every later edge: valid pulse, capture=10, ovf=0.
REQ-029 ps=2, periods 40 then 43 -> capture=10 both times, ovf=0.
REQ-030 COUNT_BITS=8, ps=0, period 300 then period 20 -> capture=255 with ovf=1, then capture=20 with ovf=0.
REQ-031 Steady 10-clock periods; switch ps 0->3 mid-interval -> that capture=10, following capture=1 (floor(10/8)).
REQ-032 en dropped for 5 clocks mid-interval then raised -> busy=0 while low; next edge arms only (no valid, capture holds 10); edge after that captures normally.
REQ-033 rst pulsed mid-interval after a capture of 10 -> capture=0, ovf=0, busy=0 during rst; the first edge after release arms only.
